// File: rtl/axis_join_pkg.sv
// Shared types and default sizing for the AXI-Stream joiner.
package axis_join_pkg;

   localparam int DEF_N_STREAMS  = 3;
   localparam int DEF_WORD_WIDTH = 8;
   localparam int DEF_WORDS      = 8;
   localparam int DEF_BEATS_BITS = 16;
   localparam int PKT_CNT_BITS   = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PACKET = 2'd1,
      DRAIN  = 2'd2
   } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice with a registered ready. The output register
// carries the presented beat; the skid register absorbs the one beat that
// can arrive while ready is still high after the consumer stalls.
// en_i gates ready so a disabled stream never accepts data.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o
);

   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  sk_valid_q, sk_valid_d;
   logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
   logic                  rdy_q, rdy_d;
   logic                  accept;

   // Next-state for the output slot, the skid slot and the registered ready.
   always_comb begin
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      sk_valid_d = sk_valid_q;
      sk_data_d  = sk_data_q;
      accept     = s_valid_i & rdy_q;
      if (m_ready_i || !m_valid_q) begin
         if (sk_valid_q) begin
            m_valid_d  = 1'b1;
            m_data_d   = sk_data_q;
            sk_valid_d = 1'b0;
         end else begin
            m_valid_d = accept;
            if (accept) m_data_d = s_data_i;
         end
      end else if (accept) begin
         sk_valid_d = 1'b1;
         sk_data_d  = s_data_i;
      end
      rdy_d = en_i & ~sk_valid_d;
   end

   // Slice registers; ready comes up on the first edge after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         sk_valid_q <= 1'b0;
         sk_data_q  <= '0;
         rdy_q      <= 1'b0;
      end else begin
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         sk_valid_q <= sk_valid_d;
         sk_data_q  <= sk_data_d;
         rdy_q      <= rdy_d;
      end
   end

   assign s_ready_o = rdy_q;
   assign m_valid_o = m_valid_q;
   assign m_data_o  = m_data_q;

endmodule

// File: rtl/axis_stream_joiner.sv
// Joins N skid-buffered AXI-Stream inputs into one lockstep beat.
//
//  state  | meaning
//  IDLE   | between packets; active mask follows cfg_mask while no beat is shown
//  PACKET | inside a packet; mask frozen
//  DRAIN  | tlast mismatch seen; discard lagging streams up to their tlast
module axis_stream_joiner
   import axis_join_pkg::*;
#(
   parameter int N_STREAMS  = DEF_N_STREAMS,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int WORDS      = DEF_WORDS,
   parameter int BEATS_BITS = DEF_BEATS_BITS
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [N_STREAMS-1:0]              cfg_mask,
   input  logic [N_STREAMS*WORDS*WORD_WIDTH-1:0] s_tdata,
   input  logic [N_STREAMS*WORDS-1:0]        s_tkeep,
   input  logic [N_STREAMS-1:0]              s_tvalid,
   input  logic [N_STREAMS-1:0]              s_tlast,
   output logic [N_STREAMS-1:0]              s_tready,
   output logic [N_STREAMS*WORDS*WORD_WIDTH-1:0] m_tdata,
   output logic [N_STREAMS*WORDS-1:0]        m_tkeep,
   output logic                              m_tvalid,
   output logic                              m_tlast,
   input  logic                              m_tready,
   output logic [BEATS_BITS-1:0]             beat_count,
   output logic [PKT_CNT_BITS-1:0]           packet_count,
   output logic                              err_tlast
);

   localparam int SLICE_W = WORDS * WORD_WIDTH;
   localparam int BUF_W   = SLICE_W + WORDS + 1;

   state_t                  state_q, state_d;
   logic [N_STREAMS-1:0]    act_mask_q, act_mask_d;
   logic [N_STREAMS-1:0]    done_mask_q, done_mask_d;
   logic [BEATS_BITS-1:0]   beat_q, beat_d;
   logic [PKT_CNT_BITS-1:0] pkt_q, pkt_d;
   logic                    err_q, err_d;
   logic [N_STREAMS-1:0]    b_valid, b_last, b_pop;
   logic                    join_valid, any_last, all_last, hs;

   for (genvar g = 0; g < N_STREAMS; g++) begin : g_stream
      logic [BUF_W-1:0] in_word, out_word;
      assign in_word = {s_tlast[g], s_tkeep[g*WORDS +: WORDS], s_tdata[g*SLICE_W +: SLICE_W]};
      axis_skid_buffer #(.DATA_WIDTH(BUF_W)) u_skid (
         .clk_i     (aclk),
         .rst_i     (areset),
         .en_i      (act_mask_d[g]),
         .s_valid_i (s_tvalid[g]),
         .s_ready_o (s_tready[g]),
         .s_data_i  (in_word),
         .m_valid_o (b_valid[g]),
         .m_ready_i (b_pop[g]),
         .m_data_o  (out_word)
      );
      assign b_last[g] = out_word[BUF_W-1];
      assign m_tkeep[g*WORDS +: WORDS]     = out_word[SLICE_W +: WORDS] & {WORDS{act_mask_q[g]}};
      assign m_tdata[g*SLICE_W +: SLICE_W] = out_word[SLICE_W-1:0] & {SLICE_W{act_mask_q[g]}};
   end

   // Join: valid only when every enabled buffer holds a beat.
   always_comb begin
      join_valid = (|act_mask_q) && ((b_valid | ~act_mask_q) == '1);
      any_last   = |(b_last & act_mask_q);
      all_last   = ((b_last | ~act_mask_q) == '1);
      m_tvalid   = join_valid && (state_q != DRAIN);
      m_tlast    = m_tvalid & any_last;
      hs         = m_tvalid & m_tready;
   end

   // FSM next state, buffer pops and the mask bookkeeping.
   always_comb begin
      state_d     = state_q;
      act_mask_d  = act_mask_q;
      done_mask_d = done_mask_q;
      b_pop       = '0;
      unique case (state_q)
         IDLE, PACKET: begin
            // Mask may only move while nothing is being presented downstream.
            if (state_q == IDLE && !m_tvalid) act_mask_d = cfg_mask;
            if (hs) begin
               b_pop = act_mask_q;
               if (!any_last) begin
                  state_d = PACKET;
               end else if (all_last) begin
                  state_d = IDLE;
               end else begin
                  state_d     = DRAIN;
                  done_mask_d = b_last & act_mask_q;
               end
            end
         end
         DRAIN: begin
            b_pop       = act_mask_q & ~done_mask_q & b_valid;
            done_mask_d = done_mask_q | (b_pop & b_last);
            if (done_mask_d == act_mask_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Beat/packet counters and the sticky mismatch flag.
   always_comb begin
      beat_d = beat_q;
      pkt_d  = pkt_q;
      err_d  = err_q;
      if (hs) begin
         if (any_last) begin
            beat_d = '0;
            pkt_d  = pkt_q + 1'b1;
            if (!all_last) err_d = 1'b1;
         end else if (beat_q != '1) begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         act_mask_q  <= '0;
         done_mask_q <= '0;
         beat_q      <= '0;
         pkt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_mask_q  <= act_mask_d;
         done_mask_q <= done_mask_d;
         beat_q      <= beat_d;
         pkt_q       <= pkt_d;
         err_q       <= err_d;
      end
   end

   assign beat_count   = beat_q;
   assign packet_count = pkt_q;
   assign err_tlast    = err_q;

endmodule

// File: tb/tb_axis_stream_joiner.sv
// Directed bench for axis_stream_joiner: a table of packet scenarios with
// hand-computed beat/packet totals, a queue model of the joined output, and
// hand-written reset and zero-mask sequences.
module tb_axis_stream_joiner;
   import axis_join_pkg::*;

   localparam int NS = 3;
   localparam int WW = 8;
   localparam int NW = 8;
   localparam int BB = 16;
   localparam int SW = NW * WW;

   logic              aclk = 1'b0;
   logic              areset;
   logic [NS-1:0]     cfg_mask;
   logic [NS*SW-1:0]  s_tdata;
   logic [NS*NW-1:0]  s_tkeep;
   logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
   logic [NS*SW-1:0]  m_tdata;
   logic [NS*NW-1:0]  m_tkeep;
   logic              m_tvalid, m_tlast, m_tready;
   logic [BB-1:0]     beat_count;
   logic [15:0]       packet_count;
   logic              err_tlast;

   always #5 aclk = ~aclk;

   axis_stream_joiner #(.N_STREAMS(NS), .WORD_WIDTH(WW), .WORDS(NW), .BEATS_BITS(BB)) dut (
      .aclk(aclk), .areset(areset), .cfg_mask(cfg_mask),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .beat_count(beat_count), .packet_count(packet_count), .err_tlast(err_tlast)
   );

   typedef struct { logic [SW-1:0] d; logic [NW-1:0] k; logic l; } sbeat_t;
   typedef struct { logic [NS*SW-1:0] d; logic [NS*NW-1:0] k; logic l; logic [BB-1:0] bc; } obeat_t;
   typedef struct {
      logic [2:0] mask; int n_pkts; int len0; int len1; int len2;
      int rdy_pct; int vld_pct; bit glitch; bit drive_dis;
      int exp_beats; int exp_pkts; bit exp_err;
   } rec_t;

   int n_vec = 0;
   int n_err = 0;

   sbeat_t sq[NS][$];
   obeat_t eq[$];

   bit            run = 0;
   logic [NS-1:0] cur_mask = '0;
   int            rdy_pct = 100, vld_pct = 100;
   bit            drive_dis = 0;
   logic [NS-1:0] hs_in_p;
   bit            hs_out_p, prev_stall, dis_rdy_seen, valid_seen;
   logic [NS*SW+NS*NW:0] cap_w, prev_w;
   int            outs_got, first_cyc, last_cyc, cyc = 0;
   int            pc_run = 0;
   int            exp_pc = 0;
   bit            exp_err = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Source/sink driver and output monitor, all on the falling edge.
   always @(negedge aclk) begin : drv
      obeat_t e;
      cyc++;
      if (!run) begin
         s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b0;
         hs_in_p = '0; hs_out_p = 0; prev_stall = 0; dis_rdy_seen = 0; valid_seen = 0;
         outs_got = 0; first_cyc = 0; last_cyc = 0;
      end else begin
         for (int i = 0; i < NS; i++)
            if (hs_in_p[i] && sq[i].size() > 0) void'(sq[i].pop_front());
         if (hs_out_p) begin
            if (eq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL extra_beat: got data %0h expected no beat", cap_w);
            end else begin
               e = eq.pop_front();
               chk("m_tdata", cap_w[NS*SW+NS*NW:NS*NW+1], e.d);
               chk("m_tkeep", cap_w[NS*NW:1], e.k);
               chk("m_tlast", cap_w[0], e.l);
               chk("beat_count", beat_count, e.bc);
               if (e.l) pc_run++;
               chk("packet_count_run", packet_count, pc_run[15:0]);
            end
            if (outs_got == 0) first_cyc = cyc;
            last_cyc = cyc;
            outs_got++;
         end
         for (int i = 0; i < NS; i++) begin
            if (cur_mask[i]) begin
               if (!(s_tvalid[i] && !hs_in_p[i])) begin
                  if (sq[i].size() > 0 && $urandom_range(99) < vld_pct) begin
                     s_tvalid[i] = 1'b1;
                     s_tdata[i*SW +: SW] = sq[i][0].d;
                     s_tkeep[i*NW +: NW] = sq[i][0].k;
                     s_tlast[i] = sq[i][0].l;
                  end else begin
                     s_tvalid[i] = 1'b0;
                  end
               end
            end else begin
               s_tvalid[i] = drive_dis;
               s_tdata[i*SW +: SW] = {$urandom, $urandom};
               s_tkeep[i*NW +: NW] = 8'($urandom);
               s_tlast[i] = 1'b0;
            end
         end
         m_tready = ($urandom_range(99) < rdy_pct);
         if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_beat", {m_tdata, m_tkeep, m_tlast}, prev_w);
         end
         hs_in_p  = s_tvalid & s_tready & cur_mask;
         if ((s_tready & ~cur_mask) != '0) dis_rdy_seen = 1;
         if (m_tvalid) valid_seen = 1;
         hs_out_p   = m_tvalid & m_tready;
         cap_w      = {m_tdata, m_tkeep, m_tlast};
         prev_stall = m_tvalid & ~m_tready;
         prev_w     = cap_w;
      end
   end

   task automatic tick();
      @(negedge aclk);
      #1;
   endtask

   // Fill stream queues and the expected joined-beat queue for one record.
   task automatic load(input rec_t r);
      int lens[NS];
      int minlen;
      lens = '{r.len0, r.len1, r.len2};
      minlen = 1 << 30;
      for (int i = 0; i < NS; i++) if (r.mask[i] && lens[i] < minlen) minlen = lens[i];
      for (int p = 0; p < r.n_pkts; p++) begin
         int base[NS];
         for (int i = 0; i < NS; i++) begin
            base[i] = sq[i].size();
            if (r.mask[i]) begin
               for (int n = 0; n < lens[i]; n++) begin
                  sbeat_t b;
                  b.d = {$urandom, $urandom};
                  b.k = 8'($urandom);
                  b.l = (n == lens[i] - 1);
                  sq[i].push_back(b);
               end
            end
         end
         for (int j = 0; j < minlen; j++) begin
            obeat_t o;
            o.d = '0;
            o.k = '0;
            for (int i = 0; i < NS; i++) begin
               if (r.mask[i]) begin
                  o.d[i*SW +: SW] = sq[i][base[i] + j].d;
                  o.k[i*NW +: NW] = sq[i][base[i] + j].k;
               end
            end
            o.l  = (j == minlen - 1);
            o.bc = o.l ? '0 : BB'(j + 1);
            eq.push_back(o);
         end
      end
   endtask

   task automatic start(input rec_t r);
      cfg_mask  = r.mask;
      cur_mask  = r.mask;
      rdy_pct   = r.rdy_pct;
      vld_pct   = r.vld_pct;
      drive_dis = r.drive_dis;
      repeat (3) tick();
      load(r);
      run = 1;
   endtask

   function automatic bit queues_empty();
      bit z;
      z = (eq.size() == 0);
      for (int i = 0; i < NS; i++) if (sq[i].size() != 0) z = 0;
      return z;
   endfunction

   task automatic run_rec(input rec_t r, input string tag);
      int budget;
      bit glitched;
      glitched = 0;
      start(r);
      budget = 40 + r.exp_beats * 20;
      while (budget > 0 && !queues_empty()) begin
         tick();
         budget--;
         if (r.glitch && !glitched && outs_got >= 1) begin
            cfg_mask = ~r.mask;
            glitched = 1;
         end
      end
      if (budget == 0) begin
         n_vec++; n_err++;
         $display("FAIL %s timeout: got %0d beats expected %0d", tag, outs_got, r.exp_beats);
      end
      repeat (r.mask == '0 ? 20 : 4) tick();
      exp_pc  += r.exp_pkts;
      exp_err |= r.exp_err;
      chk({tag, "_beats"}, outs_got, r.exp_beats);
      chk({tag, "_packet_count"}, packet_count, exp_pc[15:0]);
      chk({tag, "_beat_count_end"}, beat_count, '0);
      chk({tag, "_err_tlast"}, err_tlast, exp_err);
      if (r.drive_dis) chk({tag, "_disabled_ready"}, dis_rdy_seen, 1'b0);
      if (r.mask == '0) chk({tag, "_valid_seen"}, valid_seen, 1'b0);
      if (r.rdy_pct == 100 && r.vld_pct == 100 && !r.exp_err && r.exp_beats > 0)
         chk({tag, "_throughput_span"}, last_cyc - first_cyc, r.exp_beats - 1);
      run = 0;
      tick();
   endtask

   rec_t recs[8];
   rec_t post_rst, zero_rec;

   initial begin
      int budget;
      recs[0] = '{3'b111,   3, 4, 4, 4, 100, 100, 0, 0,   12,   3, 0};
      recs[1] = '{3'b101,   2, 3, 3, 3, 100, 100, 0, 1,    6,   2, 0};
      recs[2] = '{3'b111,   1, 3, 5, 5, 100, 100, 0, 0,    3,   1, 1};
      recs[3] = '{3'b111,   1, 2, 2, 2, 100, 100, 0, 0,    2,   1, 0};
      recs[4] = '{3'b111,   1, 4, 4, 4, 100, 100, 1, 0,    4,   1, 0};
      recs[5] = '{3'b111,   1, 1, 1, 1, 100, 100, 0, 0,    1,   1, 0};
      recs[6] = '{3'b111, 250, 8, 8, 8,  50,  60, 0, 0, 2000, 250, 0};
      recs[7] = '{3'b011,   4, 2, 2, 6,  70,  80, 0, 1,    8,   4, 0};
      post_rst = '{3'b111,  1, 4, 4, 4, 100, 100, 0, 0,    4,   1, 0};
      zero_rec = '{3'b000,  0, 2, 2, 2, 100, 100, 0, 1,    0,   0, 0};

      areset   = 1'b1;
      cfg_mask = 3'b111;
      repeat (3) tick();
      chk("rst_s_tready", s_tready, '0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_beat_count", beat_count, '0);
      chk("rst_packet_count", packet_count, '0);
      chk("rst_err_tlast", err_tlast, 1'b0);
      areset = 1'b0;
      chk("rst_release_ready_low", s_tready, '0);
      tick();
      chk("rst_release_ready_up", s_tready, 3'b111);

      for (int k = 0; k < 8; k++) run_rec(recs[k], $sformatf("rec%0d", k));

      // Reset pulsed on beat 2 of a 4-beat packet.
      start(post_rst);
      budget = 60;
      while (budget > 0 && outs_got < 2) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         n_vec++; n_err++;
         $display("FAIL midrst_wait: got %0d beats expected 2", outs_got);
      end
      chk("midrst_beat_count_before", beat_count, 16'd2);
      run = 0;
      areset = 1'b1;
      #1;
      chk("midrst_s_tready", s_tready, '0);
      chk("midrst_m_tvalid", m_tvalid, 1'b0);
      chk("midrst_m_tlast", m_tlast, 1'b0);
      chk("midrst_m_tdata", m_tdata, '0);
      chk("midrst_m_tkeep", m_tkeep, '0);
      chk("midrst_beat_count", beat_count, '0);
      chk("midrst_packet_count", packet_count, '0);
      chk("midrst_err_tlast", err_tlast, 1'b0);
      for (int i = 0; i < NS; i++) sq[i].delete();
      eq.delete();
      repeat (2) tick();
      areset  = 1'b0;
      exp_pc  = 0;
      pc_run  = 0;
      exp_err = 0;
      run_rec(post_rst, "postrst");

      run_rec(zero_rec, "zeromask");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
